// File: rtl/data_bus_pkg.sv
// Shared command and state encodings for the data bus transceiver.
// Imported by the interface, the FIFO and the top level.
package data_bus_pkg;

   localparam logic [1:0] CMD_PUSH    = 2'b00;
   localparam logic [1:0] CMD_SEND    = 2'b01;
   localparam logic [1:0] CMD_READ    = 2'b10;
   localparam logic [1:0] CMD_CAPTURE = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'b00;
   localparam state_t ST_TURN  = 2'b01;
   localparam state_t ST_DRIVE = 2'b10;

   // Occupancy counter width: must be able to hold the value DEPTH itself.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/data_bus_transceiver_if.sv
// Command/status bundle between the core side and the transceiver.
// The tri-state data_bus stays a plain module port.
interface data_bus_transceiver_if
   import data_bus_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) ();

   localparam int CW = cnt_width(DEPTH);

   // Handshake: a command (path, core_in) is taken at a rising clk_2 edge
   // only when enable_n is low; there is no ready, rejected commands simply
   // leave the state alone. core_valid pulses one cycle when core_out updates.
   logic             enable_n;
   logic [1:0]       path;
   logic [WIDTH-1:0] core_in;
   logic [WIDTH-1:0] core_out;
   logic             core_valid;
   logic             busy;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             underflow;
   state_t           state_dbg;
   logic             own_bus_dbg;
   logic             bus_oe_dbg;

   modport master (
      output enable_n, path, core_in,
      input  core_out, core_valid, busy, count, full, empty,
      input  overflow, underflow, state_dbg, own_bus_dbg, bus_oe_dbg
   );

   modport slave (
      input  enable_n, path, core_in,
      output core_out, core_valid, busy, count, full, empty,
      output overflow, underflow, state_dbg, own_bus_dbg, bus_oe_dbg
   );

endinterface

// File: rtl/bus_fifo.sv
// Transmit FIFO: power-of-two depth, pointers wrap naturally, head is
// combinational so the pop edge can latch it directly.
module bus_fifo
   import data_bus_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   localparam int CW   = cnt_width(DEPTH),
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_2,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clk_2) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/data_bus_transceiver.sv
// Half-duplex bus transceiver: queues words, drives them onto a shared
// tri-state bus after an optional turnaround, and captures inbound words.
module data_bus_transceiver
   import data_bus_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int DEPTH      = 4,
   parameter int TURNAROUND = 1
) (
   input  logic                  clk_2,
   input  logic                  rst_n,
   data_bus_transceiver_if.slave bus,
   inout  wire [WIDTH-1:0]       data_bus
);

   localparam int CW = cnt_width(DEPTH);
   localparam logic [3:0] TURN_INIT = 4'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

   state_t           state;
   state_t           next_state;
   logic [3:0]       turn_cnt;
   logic [3:0]       turn_nxt;

   logic             busy_w;
   logic             bus_oe;
   logic             pop_req;

   logic [WIDTH-1:0] head;
   logic [CW-1:0]    fifo_count;
   logic             fifo_full;
   logic             fifo_empty;

   logic [WIDTH-1:0] drive_reg;
   logic [WIDTH-1:0] rx_reg;
   logic [WIDTH-1:0] core_out_r;
   logic             core_valid_r;
   logic             own_bus;
   logic             overflow_r;
   logic             underflow_r;

   logic             cmd_push;
   logic             send_ok;
   logic             send_under;
   logic             capture_ok;
   logic             read_ok;

   // PUSH ignores busy; the other commands only act from IDLE.
   assign cmd_push   = !bus.enable_n && (bus.path == CMD_PUSH);
   assign send_ok    = !bus.enable_n && (bus.path == CMD_SEND) && !busy_w && !fifo_empty;
   assign send_under = !bus.enable_n && (bus.path == CMD_SEND) && !busy_w && fifo_empty;
   assign capture_ok = !bus.enable_n && (bus.path == CMD_CAPTURE) && !busy_w;
   assign read_ok    = !bus.enable_n && (bus.path == CMD_READ) && !busy_w;

   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         turn_cnt <= '0;
      end else begin
         state    <= next_state;
         turn_cnt <= turn_nxt;
      end
   end

   always_comb begin
      next_state = state;
      turn_nxt   = turn_cnt;
      case (state)
         ST_IDLE: begin
            if (send_ok) begin
               if (own_bus || (TURNAROUND == 0)) begin
                  next_state = ST_DRIVE;
               end else begin
                  next_state = ST_TURN;
                  turn_nxt   = TURN_INIT;
               end
            end
         end
         ST_TURN: begin
            if (turn_cnt == 4'd0) next_state = ST_DRIVE;
            else                  turn_nxt   = turn_cnt - 4'd1;
         end
         ST_DRIVE: next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // Pop on the edge that enters DRIVE; rst_n gates the driver so the bus
   // is released asynchronously even before the state register settles.
   always_comb begin
      busy_w  = (state != ST_IDLE);
      bus_oe  = (state == ST_DRIVE) && rst_n;
      pop_req = (next_state == ST_DRIVE) && (state != ST_DRIVE);
   end

   bus_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_2 (clk_2),
      .rst_n (rst_n),
      .push  (cmd_push),
      .pop   (pop_req),
      .din   (bus.core_in),
      .head  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         drive_reg    <= '0;
         rx_reg       <= '0;
         core_out_r   <= '0;
         core_valid_r <= 1'b0;
         own_bus      <= 1'b0;
         overflow_r   <= 1'b0;
         underflow_r  <= 1'b0;
      end else begin
         if (pop_req) begin
            drive_reg <= head;
            own_bus   <= 1'b1;
         end else if (capture_ok) begin
            own_bus   <= 1'b0;
         end
         if (capture_ok)            rx_reg      <= data_bus;
         if (read_ok)               core_out_r  <= rx_reg;
         core_valid_r <= read_ok;
         if (cmd_push && fifo_full) overflow_r  <= 1'b1;
         if (send_under)            underflow_r <= 1'b1;
      end
   end

   assign data_bus = bus_oe ? drive_reg : {WIDTH{1'bz}};

   assign bus.core_out    = core_out_r;
   assign bus.core_valid  = core_valid_r;
   assign bus.busy        = busy_w;
   assign bus.count       = fifo_count;
   assign bus.full        = fifo_full;
   assign bus.empty       = fifo_empty;
   assign bus.overflow    = overflow_r;
   assign bus.underflow   = underflow_r;
   assign bus.state_dbg   = state;
   assign bus.own_bus_dbg = own_bus;
   assign bus.bus_oe_dbg  = bus_oe;

endmodule
